perf_page_sched: RTL and testbench
==================================

// Module: perf_page_sched
// PURPOSE
//  Sequencer for the 7-segment performance-counter display. Debounces two push-buttons and
//  selects one of 4 display pages, either manually from switches or by auto-rotation.
//  Optionally freezes a snapshot of all counters and counts user interactions.
//  Sits between the CPU telemetry counters and the dec7seg instances in the board top level.
// PARAMETERS
//  CNT_W      9   width of every telemetry counter and display value
//  DEB_CYC    3   consecutive stable samples required to accept a key level change (>=1)
//  PAGE_HOLD  16  clk cycles each page is shown in auto mode (>=2)
// PORTS
//  clk           in   1          system clock (slow CPU clock), rising edge
//  reset_n       in   1          asynchronous, active-low reset
//  key_next_n    in   1          raw button, active-low: advance page / counts as interaction
//  key_frz_n     in   1          raw button, active-low: toggle freeze / counts as interaction
//  sw_auto       in   1          1 = auto-rotate pages, 0 = manual page from sw_page
//  sw_page       in   2          manual page select
//  cnt_in        in   11*CNT_W   packed counters, idx 0..10: cycle,instr,jump,brT,brNT,stall,load,store,flush,fwd,alu
//  page          out  2          page currently displayed
//  frozen        out  1          1 = outputs come from snapshot registers
//  user_cnt      out  CNT_W      live user-interaction count
//  hex2_val      out  CNT_W      value for HEX5/4
//  hex1_val      out  CNT_W      value for HEX3/2
//  hex0_val      out  CNT_W      value for HEX1/0
// BEHAVIOUR
//  Reset: page=0, frozen=0, user_cnt=0, hexN_val=0, snapshot regs=0, timer=0, debouncers in IDLE.
//  Debouncer FSM (per key): IDLE -(key low)-> PRESS_CHK -(low DEB_CYC samples)-> HELD,
//   emits 1-cycle press pulse on the transition into HELD; PRESS_CHK -(high)-> IDLE.
//   HELD -(key high)-> REL_CHK -(high DEB_CYC samples)-> IDLE; REL_CHK -(low)-> HELD.
//   Press-to-pulse latency = DEB_CYC+1 clk. Holding a key yields exactly one pulse.
//  user_cnt: +1 per pulse, +2 when both pulses occur in the same cycle; wraps mod 2^CNT_W.
//  Manual (sw_auto=0): page <= sw_page each cycle; next pulse ignored for paging; timer held at 0.
//  Auto (sw_auto=1): timer counts 0..PAGE_HOLD-1; at PAGE_HOLD-1, page <= page+1 (3 wraps to 0), timer <= 0.
//   Next pulse: page <= page+1, timer <= 0; same-cycle next pulse and timer expiry advance ONE page.
//   Manual->auto entry: keep the current page, timer restarts at 0.
//  Freeze: frz pulse toggles frozen. On 0->1, all 11 cnt_in and user_cnt are latched into
//   snapshot regs in that same edge. While frozen, snapshots do not change and user_cnt keeps counting live.
//  Page map (src = snapshot if frozen else live):
//   0: cycle,instr,user   1: jump,brT,brNT   2: stall,load,store   3: flush,fwd,alu
//  hexN_val are registered: a change in page/src is visible 1 clk later.
//  Reset asserted mid-debounce or mid-freeze: all state returns to reset values asynchronously.
//   The first pulse after release needs a full fresh debounce.
// STRUCTURE
//  Package perf_pkg: NUM_CNT=11; index localparams CI_CYCLE..CI_ALU;
//   typedef enum logic[1:0] {PG_OVERVIEW,PG_BRANCH,PG_MEMHAZ,PG_DEBUG} page_t; debounce state enum.
//  Sub-module key_debounce (params DEB_CYC; ports clk, reset_n, key_n, pressed, pulse), instantiated twice.
// TESTING
//  1 Reset, sw_auto=0, sw_page=2, cnt_in idx5/6/7=7/8/9 -> page=2, hex2/1/0=7/8/9 one clk after page.
//  2 key_next_n low 1 cycle then high -> no pulse, user_cnt=0. Low 10 cycles -> exactly one pulse, user_cnt=1.
//  3 sw_auto=1 from page 3, PAGE_HOLD=16 -> page 0 after 16 clk; next pulse at timer=15 -> single advance to 1.
//  4 Freeze with cycle=0x20, then cycle ramps to 0x80 -> hex2_val stays 0x20. Second freeze pulse -> live value.
//  5 Both keys debounced to pulse in same cycle from user_cnt=0x1FF -> user_cnt=0x001, frozen toggles.
//  6 reset_n low while in PRESS_CHK with frozen=1 -> frozen=0, page=0, no pulse after release.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared types and counter indices for the performance-counter page sequencer.
// Counter order matches the packed telemetry bus from the CPU.
package perf_pkg;

    localparam int NUM_CNT  = 11;
    localparam int CI_CYCLE = 0;
    localparam int CI_INSTR = 1;
    localparam int CI_JUMP  = 2;
    localparam int CI_BRT   = 3;
    localparam int CI_BRNT  = 4;
    localparam int CI_STALL = 5;
    localparam int CI_LOAD  = 6;
    localparam int CI_STORE = 7;
    localparam int CI_FLUSH = 8;
    localparam int CI_FWD   = 9;
    localparam int CI_ALU   = 10;

    typedef enum logic [1:0] {
        PG_OVERVIEW,
        PG_BRANCH,
        PG_MEMHAZ,
        PG_DEBUG
    } page_t;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_PRESS_CHK,
        DB_HELD,
        DB_REL_CHK
    } deb_state_t;

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer: a level change is accepted after DEB_CYC stable samples.
// pulse is high for the one cycle whose clock edge moves the FSM into HELD.
module key_debounce
    import perf_pkg::*;
#(
    parameter int DEB_CYC = 3
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_n,
    output logic pressed,
    output logic pulse
);

    localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

    deb_state_t state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= DB_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        unique case (state)
            DB_IDLE: begin
                if (!key_n) state_nxt = DB_PRESS_CHK;
            end
            DB_PRESS_CHK: begin
                if (key_n)            state_nxt = DB_IDLE;
                else if (cnt == LAST) state_nxt = DB_HELD;
                else                  cnt_nxt   = cnt + 1'b1;
            end
            DB_HELD: begin
                if (key_n) state_nxt = DB_REL_CHK;
            end
            DB_REL_CHK: begin
                if (!key_n)           state_nxt = DB_HELD;
                else if (cnt == LAST) state_nxt = DB_IDLE;
                else                  cnt_nxt   = cnt + 1'b1;
            end
        endcase
    end

    always_comb begin
        pressed = (state == DB_HELD) || (state == DB_REL_CHK);
        pulse   = (state == DB_PRESS_CHK) && !key_n && (cnt == LAST);
    end

endmodule

// File: rtl/perf_page_sched.sv
// Page sequencer for the 7-segment performance display: paging, auto-rotate,
// freeze snapshot and user-interaction counting.
module perf_page_sched
    import perf_pkg::*;
#(
    parameter int CNT_W     = 9,
    parameter int DEB_CYC   = 3,
    parameter int PAGE_HOLD = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     key_next_n,
    input  logic                     key_frz_n,
    input  logic                     sw_auto,
    input  logic [1:0]               sw_page,
    input  logic [NUM_CNT*CNT_W-1:0] cnt_in,
    output logic [1:0]               page,
    output logic                     frozen,
    output logic [CNT_W-1:0]         user_cnt,
    output logic [CNT_W-1:0]         hex2_val,
    output logic [CNT_W-1:0]         hex1_val,
    output logic [CNT_W-1:0]         hex0_val
);

    localparam int TW = $clog2(PAGE_HOLD);
    localparam logic [TW-1:0] T_LAST = TW'(PAGE_HOLD - 1);

    logic             next_pulse, frz_pulse;
    logic [1:0]       unused_held;
    page_t            page_q;
    logic [TW-1:0]    timer;
    logic             frozen_q;
    logic [CNT_W-1:0] live [NUM_CNT];
    logic [CNT_W-1:0] snap [NUM_CNT];
    logic [CNT_W-1:0] src  [NUM_CNT];
    logic [CNT_W-1:0] snap_user, src_user;
    logic [CNT_W-1:0] h2, h1, h0;

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_next (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_next_n),
        .pressed (unused_held[0]),
        .pulse   (next_pulse)
    );

    key_debounce #(.DEB_CYC(DEB_CYC)) u_deb_frz (
        .clk     (clk),
        .reset_n (reset_n),
        .key_n   (key_frz_n),
        .pressed (unused_held[1]),
        .pulse   (frz_pulse)
    );

    always_comb begin
        for (int i = 0; i < NUM_CNT; i++) begin
            live[i] = cnt_in[i*CNT_W +: CNT_W];
            src[i]  = frozen_q ? snap[i] : live[i];
        end
        src_user = frozen_q ? snap_user : user_cnt;
    end

    // A next pulse coinciding with timer expiry still advances a single page.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            page_q <= PG_OVERVIEW;
            timer  <= '0;
        end else if (!sw_auto) begin
            page_q <= page_t'(sw_page);
            timer  <= '0;
        end else if (next_pulse || timer == T_LAST) begin
            page_q <= page_t'(page_q + 2'd1);
            timer  <= '0;
        end else begin
            timer  <= timer + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            user_cnt <= '0;
        end else begin
            user_cnt <= user_cnt + CNT_W'(next_pulse) + CNT_W'(frz_pulse);
        end
    end

    // Snapshot takes the pre-edge user count, before this edge's increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frozen_q  <= 1'b0;
            snap_user <= '0;
            for (int i = 0; i < NUM_CNT; i++) snap[i] <= '0;
        end else if (frz_pulse) begin
            frozen_q <= ~frozen_q;
            if (!frozen_q) begin
                snap      <= live;
                snap_user <= user_cnt;
            end
        end
    end

    always_comb begin
        h2 = '0;
        h1 = '0;
        h0 = '0;
        unique case (page_q)
            PG_OVERVIEW: begin
                h2 = src[CI_CYCLE];
                h1 = src[CI_INSTR];
                h0 = src_user;
            end
            PG_BRANCH: begin
                h2 = src[CI_JUMP];
                h1 = src[CI_BRT];
                h0 = src[CI_BRNT];
            end
            PG_MEMHAZ: begin
                h2 = src[CI_STALL];
                h1 = src[CI_LOAD];
                h0 = src[CI_STORE];
            end
            PG_DEBUG: begin
                h2 = src[CI_FLUSH];
                h1 = src[CI_FWD];
                h0 = src[CI_ALU];
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hex2_val <= '0;
            hex1_val <= '0;
            hex0_val <= '0;
        end else begin
            hex2_val <= h2;
            hex1_val <= h1;
            hex0_val <= h0;
        end
    end

    assign page   = page_q;
    assign frozen = frozen_q;

endmodule

// File: tb/tb_perf_page_sched.sv
// Randomized bench for perf_page_sched against a cycle-level behavioural model.
// Directed scenarios first, then random key bouncing, switch changes and resets.
module tb_perf_page_sched;
    import perf_pkg::*;

    localparam int CNT_W     = 9;
    localparam int DEB_CYC   = 3;
    localparam int PAGE_HOLD = 16;
    localparam int UMASK     = (1 << CNT_W) - 1;

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     key_next_n, key_frz_n;
    logic                     sw_auto;
    logic [1:0]               sw_page;
    logic [NUM_CNT*CNT_W-1:0] cnt_in;
    logic [1:0]               page;
    logic                     frozen;
    logic [CNT_W-1:0]         user_cnt, hex2_val, hex1_val, hex0_val;

    always #5 clk = ~clk;

    perf_page_sched #(
        .CNT_W(CNT_W), .DEB_CYC(DEB_CYC), .PAGE_HOLD(PAGE_HOLD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .key_next_n (key_next_n),
        .key_frz_n  (key_frz_n),
        .sw_auto    (sw_auto),
        .sw_page    (sw_page),
        .cnt_in     (cnt_in),
        .page       (page),
        .frozen     (frozen),
        .user_cnt   (user_cnt),
        .hex2_val   (hex2_val),
        .hex1_val   (hex1_val),
        .hex0_val   (hex0_val)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Model: accepted key level plus run length of disagreeing samples.
    int m_acc [2];
    int m_run [2];
    int m_page, m_timer, m_frozen, m_user, m_snap_user;
    int m_snap [NUM_CNT];
    int m_hex [3];
    int pmap [4][3] = '{'{CI_CYCLE, CI_INSTR, NUM_CNT},
                        '{CI_JUMP,  CI_BRT,   CI_BRNT},
                        '{CI_STALL, CI_LOAD,  CI_STORE},
                        '{CI_FLUSH, CI_FWD,   CI_ALU}};

    function automatic int cnt_val(input int i);
        return int'(cnt_in[i*CNT_W +: CNT_W]);
    endfunction

    task automatic set_cnt(input int i, input int v);
        cnt_in[i*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_acc[k] = 0;
            m_run[k] = 0;
        end
        m_page = 0; m_timer = 0; m_frozen = 0; m_user = 0; m_snap_user = 0;
        for (int i = 0; i < NUM_CNT; i++) m_snap[i] = 0;
        for (int j = 0; j < 3; j++) m_hex[j] = 0;
    endtask

    task automatic model_edge();
        int src [NUM_CNT+1];
        int lvl [2];
        int p   [2];
        for (int i = 0; i < NUM_CNT; i++)
            src[i] = m_frozen ? m_snap[i] : cnt_val(i);
        src[NUM_CNT] = m_frozen ? m_snap_user : m_user;
        for (int j = 0; j < 3; j++) m_hex[j] = src[pmap[m_page][j]];

        lvl[0] = key_next_n ? 0 : 1;
        lvl[1] = key_frz_n  ? 0 : 1;
        for (int k = 0; k < 2; k++) begin
            p[k] = 0;
            if (lvl[k] != m_acc[k]) begin
                m_run[k]++;
                if (m_run[k] == DEB_CYC + 1) begin
                    m_acc[k] = lvl[k];
                    m_run[k] = 0;
                    p[k]     = lvl[k];
                end
            end else begin
                m_run[k] = 0;
            end
        end

        if (!sw_auto) begin
            m_page  = int'(sw_page);
            m_timer = 0;
        end else if (p[0] == 1 || m_timer == PAGE_HOLD - 1) begin
            m_page  = (m_page + 1) % 4;
            m_timer = 0;
        end else begin
            m_timer++;
        end

        if (p[1] == 1) begin
            if (m_frozen == 0) begin
                for (int i = 0; i < NUM_CNT; i++) m_snap[i] = cnt_val(i);
                m_snap_user = m_user;
            end
            m_frozen = 1 - m_frozen;
        end
        m_user = (m_user + p[0] + p[1]) & UMASK;
    endtask

    task automatic check_all();
        chk("page",     32'(page),     32'(m_page));
        chk("frozen",   32'(frozen),   32'(m_frozen));
        chk("user_cnt", 32'(user_cnt), 32'(m_user));
        chk("hex2",     32'(hex2_val), 32'(m_hex[0]));
        chk("hex1",     32'(hex1_val), 32'(m_hex[1]));
        chk("hex0",     32'(hex0_val), 32'(m_hex[2]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset_n) model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic press(input logic nx, input logic fz);
        key_next_n = ~nx;
        key_frz_n  = ~fz;
        repeat (DEB_CYC + 2) tick();
        key_next_n = 1'b1;
        key_frz_n  = 1'b1;
        repeat (DEB_CYC + 2) tick();
    endtask

    int nlen, flen;

    initial begin
        reset_n    = 1'b0;
        key_next_n = 1'b1;
        key_frz_n  = 1'b1;
        sw_auto    = 1'b0;
        sw_page    = 2'd2;
        cnt_in     = '0;
        set_cnt(CI_STALL, 7);
        set_cnt(CI_LOAD, 8);
        set_cnt(CI_STORE, 9);
        model_reset();
        #2;
        check_all();
        chk("rst_hex2", 32'(hex2_val), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Manual page, hex follows one clock later
        tick();
        chk("t1_page", 32'(page), 32'd2);
        tick();
        chk("t1_hex2", 32'(hex2_val), 32'd7);
        chk("t1_hex1", 32'(hex1_val), 32'd8);
        chk("t1_hex0", 32'(hex0_val), 32'd9);

        // Glitch rejected, long hold gives one pulse
        key_next_n = 1'b0;
        tick();
        key_next_n = 1'b1;
        repeat (6) tick();
        chk("t2_glitch", 32'(user_cnt), 32'd0);
        key_next_n = 1'b0;
        repeat (10) tick();
        key_next_n = 1'b1;
        repeat (6) tick();
        chk("t2_hold", 32'(user_cnt), 32'd1);

        // Auto rotation and coincident next pulse
        sw_page = 2'd3;
        tick();
        sw_auto = 1'b1;
        repeat (15) tick();
        chk("t3_hold", 32'(page), 32'd3);
        tick();
        chk("t3_wrap", 32'(page), 32'd0);
        repeat (12) tick();
        key_next_n = 1'b0;
        repeat (DEB_CYC + 1) tick();
        chk("t3_single", 32'(page), 32'd1);
        key_next_n = 1'b1;
        repeat (6) tick();

        // Freeze holds the snapshot while live counters move
        sw_auto = 1'b0;
        sw_page = 2'd0;
        set_cnt(CI_CYCLE, 'h20);
        tick();
        press(1'b0, 1'b1);
        for (int v = 'h28; v <= 'h80; v += 8) begin
            set_cnt(CI_CYCLE, v);
            tick();
        end
        chk("t4_frz", 32'(frozen), 32'd1);
        chk("t4_snap", 32'(hex2_val), 32'h20);
        press(1'b0, 1'b1);
        chk("t4_unfrz", 32'(frozen), 32'd0);
        chk("t4_live", 32'(hex2_val), 32'h80);

        // Wraparound with simultaneous pulses
        @(posedge clk);
        #1;
        do_reset();
        repeat (255) press(1'b1, 1'b1);
        press(1'b1, 1'b0);
        chk("t5_pre", 32'(user_cnt), 32'h1FF);
        chk("t5_prefrz", 32'(frozen), 32'd1);
        press(1'b1, 1'b1);
        chk("t5_wrap", 32'(user_cnt), 32'h001);
        chk("t5_frz", 32'(frozen), 32'd0);

        // Reset during debounce while frozen
        press(1'b0, 1'b1);
        sw_page = 2'd1;
        tick();
        key_next_n = 1'b0;
        repeat (2) tick();
        do_reset();
        chk("t6_frz", 32'(frozen), 32'd0);
        chk("t6_page", 32'(page), 32'd0);
        key_next_n = 1'b1;
        repeat (10) tick();
        chk("t6_nopulse", 32'(user_cnt), 32'd0);

        // Random bouncing keys, switches, counters and resets
        nlen = 0;
        flen = 0;
        for (int c = 0; c < 4000; c++) begin
            if (nlen == 0) begin
                key_next_n = 1'($urandom_range(0, 1));
                nlen = $urandom_range(1, 9);
            end
            if (flen == 0) begin
                key_frz_n = 1'($urandom_range(0, 1));
                flen = $urandom_range(1, 9);
            end
            nlen--;
            flen--;
            if ($urandom_range(0, 63) == 0) sw_auto = ~sw_auto;
            if ($urandom_range(0, 7) == 0) sw_page = 2'($urandom_range(0, 3));
            for (int i = 0; i < NUM_CNT; i++)
                if ($urandom_range(0, 3) == 0) set_cnt(i, int'($urandom));
            if ($urandom_range(0, 499) == 0) do_reset();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
